mby_sb_tx_egress: RTL and testbench
===================================

// Module: mby_sb_tx_egress
// PURPOSE
//   Parametrised sideband egress for MBY: buffers messages from NUM_CH internal agent channels and drives
//   them onto the sideband fabric with per-channel put/credit-up flow control. Generalises the fixed
//   8-bit posted/non-posted sideband port to any payload width and channel count.
//   Adds per-channel buffering, round-robin arbitration at message boundaries, credit-overflow detection and an idle flag for clock gating.
// PARAMETERS
//   PAYLOAD_W   8   flit width in bits (8/16/32)
//   NUM_CH      2   channel count (ch0=posted, ch1=non-posted by convention); 1..8
//   FIFO_DEPTH  8   per-channel flit FIFO depth; power of 2, >=2
//   MAX_CREDITS 4   max credits per channel the fabric may grant; CW=$clog2(MAX_CREDITS+1)
// PORTS
//   mby_secondary_clock  in   1                 sideband clock; all logic on rising edge
//   mby_secondary_reset  in   1                 asynchronous, active-high reset
//   agt_valid            in   NUM_CH            agent flit valid per channel
//   agt_ready            out  NUM_CH            FIFO can accept a flit (registered)
//   agt_payload          in   NUM_CH*PAYLOAD_W  flit data, channel c at [c*PAYLOAD_W +: PAYLOAD_W]
//   agt_eom              in   NUM_CH            flit is last of its message
//   sb_put               out  NUM_CH            one-hot flit put to fabric, per channel
//   sb_payload           out  PAYLOAD_W         flit data, valid when |sb_put
//   sb_eom               out  1                 last flit of message, valid when |sb_put
//   sb_cup               in   NUM_CH            fabric credit return, one credit per pulse-cycle
//   credit_cnt           out  NUM_CH*CW         current credit count per channel (debug)
//   cup_overflow         out  1                 sticky: credit returned while counter at MAX_CREDITS
//   tx_idle              out  1                 no buffered flits, no message in flight, no put
// BEHAVIOUR
//   Reset: FIFOs flushed, credits 0, FSM IDLE, rr pointer 0; sb_put/sb_payload/sb_eom/agt_ready/
//     cup_overflow = 0, credit_cnt = 0, tx_idle = 1. agt_ready rises the first cycle after release.
//   Ingress: flit written on agt_valid&agt_ready; agt_ready[c] = !full[c], registered from next count.
//     valid without ready: no write, agent holds. FIFO full at FIFO_DEPTH flits; one write+one pop same cycle legal.
//   Credits: counter[c] +1 on sb_cup[c], -1 when first flit of a message is put on c; both same cycle ->
//     unchanged. sb_cup at MAX_CREDITS with no consume: counter holds, cup_overflow set until reset.
//     Only the first flit consumes a credit; later flits of the message need none.
//   FSM IDLE: channel c eligible if FIFO[c] non-empty and counter[c]>0. Round-robin pick starting at rr
//     pointer; pop head flit, go SEND(c) unless that flit has eom (stay IDLE).
//   FSM SEND(c): locked to c; pop and put next flit whenever FIFO[c] non-empty, else bubble (sb_put=0,
//     lock held). Popping the eom flit returns to IDLE. No interleaving of channels within a message.
//   rr pointer <= (winner+1) mod NUM_CH when the winner's eom flit is put.
//   Output timing: sb_put/sb_payload/sb_eom are flops; flit accepted at edge N appears on sb_* in the
//     cycle after edge N+1 (2-cycle minimum latency). Back-to-back messages need no idle cycle; full
//     throughput one flit/cycle. sb_payload and sb_eom = 0 when no put.
//   tx_idle = all FIFOs empty & FSM IDLE & sb_put==0 (registered).
//   Reset asserted mid-message: everything clears asynchronously; partial message discarded (fabric is
//     reset on the same domain). NUM_CH=1: arbitration degenerates, rr pointer constant 0.
// TESTING
//   1. cup[0] one cycle, then 4-flit msg A0..A3 on ch0 -> sb_put=01 four consecutive cycles, data A0..A3,
//      sb_eom only with A3; credit_cnt[0] 1->0 with A0.
//   2. No credits, 8 flits pushed on ch0 -> agt_ready[0]=0 after 8th, no sb_put; one cup -> drain begins,
//      agt_ready[0] returns 1 the cycle after first pop.
//   3. Credits 2/2, two 3-flit msgs queued per channel -> order ch0,ch1,ch0,ch1; no interleave; 12 put
//      cycles back-to-back.
//   4. Ch0 msg mid-send, FIFO starves for 3 cycles while ch1 eligible -> 3 bubble cycles, ch1 not granted
//      until ch0 eom.
//   5. cup with counter=4 and no consume -> credit_cnt stays 4, cup_overflow=1 until reset; cup coincident
//      with message start at count 2 -> stays 2.
//   6. Reset asserted on 2nd flit of a 4-flit msg -> sb_put=0 immediately, credit_cnt=0; after release
//      tx_idle=1, agt_ready=all-ones next cycle, no stale flits emitted.

Source files
------------

// File: rtl/mby_sb_tx_egress.sv
// Sideband egress: per-channel flit FIFOs, credit-gated round-robin message arbiter, registered put port.
// Latency 2 cycles accept-to-put; agent stalls via agt_ready on FIFO full, fabric via per-channel credits.
module mby_sb_tx_egress #(
  parameter int PAYLOAD_W   = 8,
  parameter int NUM_CH      = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_CREDITS = 4,
  parameter int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic                          mby_secondary_clock,
  input  logic                          mby_secondary_reset,
  input  logic [NUM_CH-1:0]             agt_valid,
  output logic [NUM_CH-1:0]             agt_ready,
  input  logic [NUM_CH*PAYLOAD_W-1:0]   agt_payload,
  input  logic [NUM_CH-1:0]             agt_eom,
  output logic [NUM_CH-1:0]             sb_put,
  output logic [PAYLOAD_W-1:0]          sb_payload,
  output logic                          sb_eom,
  input  logic [NUM_CH-1:0]             sb_cup,
  output logic [NUM_CH*CW-1:0]          credit_cnt,
  output logic                          cup_overflow,
  output logic                          tx_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW = PAYLOAD_W + 1;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                r_state;
  logic [RW-1:0]         r_lock;
  logic [RW-1:0]         r_rr;
  logic [NUM_CH-1:0]     r_sb_put;
  logic [PAYLOAD_W-1:0]  r_sb_payload;
  logic                  r_sb_eom;
  logic                  r_ovf;
  logic                  r_idle;

  logic [DW-1:0]         w_head_ch [NUM_CH];
  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_empty_nxt;
  logic [NUM_CH-1:0]     w_elig;
  logic [NUM_CH-1:0]     w_pop;
  logic [NUM_CH-1:0]     w_consume;
  logic [NUM_CH-1:0]     w_ovf_hit;
  logic                  w_pop_any;
  logic [RW-1:0]         w_pop_ch;
  logic [RW-1:0]         w_rr_nxt;
  logic [DW-1:0]         w_head;
  state_t                w_state_nxt;
  int                    w_idx;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DW-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_cnt;
    logic           r_rdy;
    logic [CW-1:0]  r_cred;
    logic           w_push;
    logic [AW:0]    w_cnt_nxt;

    assign w_push         = agt_valid[c] & r_rdy;
    assign w_cnt_nxt      = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop[c]);
    assign w_empty[c]     = (r_cnt == '0);
    assign w_empty_nxt[c] = (w_cnt_nxt == '0);
    assign w_elig[c]      = !w_empty[c] && (r_cred != '0);
    assign w_head_ch[c]   = r_mem[r_rptr];
    assign w_ovf_hit[c]   = sb_cup[c] & ~w_consume[c] & (r_cred == CW'(MAX_CREDITS));
    assign agt_ready[c]   = r_rdy;
    assign credit_cnt[c*CW +: CW] = r_cred;

    always_ff @(posedge mby_secondary_clock) begin
      if (w_push) r_mem[r_wptr] <= {agt_eom[c], agt_payload[c*PAYLOAD_W +: PAYLOAD_W]};
    end

    always_ff @(posedge mby_secondary_clock or posedge mby_secondary_reset) begin
      if (mby_secondary_reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_rdy  <= 1'b0;
        r_cred <= '0;
      end else begin
        if (w_push)   r_wptr <= r_wptr + 1'b1;
        if (w_pop[c]) r_rptr <= r_rptr + 1'b1;
        r_cnt <= w_cnt_nxt;
        r_rdy <= (w_cnt_nxt != (AW+1)'(FIFO_DEPTH));
        // Eligibility requires a credit, so consume never underflows; cup at max saturates.
        if (sb_cup[c] && !w_consume[c] && r_cred != CW'(MAX_CREDITS)) r_cred <= r_cred + 1'b1;
        else if (!sb_cup[c] && w_consume[c])                         r_cred <= r_cred - 1'b1;
      end
    end
  end

  always_comb begin
    w_idx     = 0;
    w_pop_any = 1'b0;
    w_pop_ch  = r_lock;
    w_pop     = '0;
    if (r_state == S_SEND) begin
      w_pop_any = !w_empty[r_lock];
    end else begin
      // Walk from the farthest offset down so the channel nearest r_rr wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        w_idx = int'(r_rr) + i;
        if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
        if (w_elig[w_idx]) begin
          w_pop_any = 1'b1;
          w_pop_ch  = RW'(w_idx);
        end
      end
    end
    if (w_pop_any) w_pop[w_pop_ch] = 1'b1;
  end

  assign w_head    = w_head_ch[w_pop_ch];
  assign w_consume = (r_state == S_IDLE) ? w_pop : '0;
  assign w_rr_nxt  = (w_pop_ch == RW'(NUM_CH - 1)) ? '0 : w_pop_ch + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop_any) w_state_nxt = w_head[PAYLOAD_W] ? S_IDLE : S_SEND;
  end

  always_ff @(posedge mby_secondary_clock or posedge mby_secondary_reset) begin
    if (mby_secondary_reset) begin
      r_state      <= S_IDLE;
      r_lock       <= '0;
      r_rr         <= '0;
      r_sb_put     <= '0;
      r_sb_payload <= '0;
      r_sb_eom     <= 1'b0;
      r_ovf        <= 1'b0;
      r_idle       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_sb_put     <= w_pop;
      r_sb_payload <= w_pop_any ? w_head[PAYLOAD_W-1:0] : '0;
      r_sb_eom     <= w_pop_any & w_head[PAYLOAD_W];
      if (w_pop_any && !w_head[PAYLOAD_W]) r_lock <= w_pop_ch;
      if (w_pop_any &&  w_head[PAYLOAD_W]) r_rr   <= w_rr_nxt;
      if (|w_ovf_hit) r_ovf <= 1'b1;
      r_idle <= (&w_empty_nxt) & (w_state_nxt == S_IDLE) & !w_pop_any;
    end
  end

  assign sb_put       = r_sb_put;
  assign sb_payload   = r_sb_payload;
  assign sb_eom       = r_sb_eom;
  assign cup_overflow = r_ovf;
  assign tx_idle      = r_idle;

endmodule

// File: tb/tb_mby_sb_tx_egress.sv
// Directed bench for mby_sb_tx_egress at default parameters (8-bit flits, 2 channels, depth 8, 4 credits).
module tb_mby_sb_tx_egress;
  localparam int PW = 8;
  localparam int NC = 2;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    agt_valid, agt_ready, agt_eom, sb_put, sb_cup;
  logic [NC*PW-1:0] agt_payload;
  logic [PW-1:0]    sb_payload;
  logic             sb_eom;
  logic [NC*CW-1:0] credit_cnt;
  logic             cup_overflow, tx_idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            q_cyc [$];
  logic [NC-1:0] q_put [$];
  logic [PW-1:0] q_dat [$];
  logic          q_eom [$];
  logic [CW-1:0] q_cr0 [$];

  always #5 clk = ~clk;

  mby_sb_tx_egress #(.PAYLOAD_W(PW), .NUM_CH(NC), .FIFO_DEPTH(8), .MAX_CREDITS(4)) dut (
    .mby_secondary_clock (clk),
    .mby_secondary_reset (rst),
    .agt_valid           (agt_valid),
    .agt_ready           (agt_ready),
    .agt_payload         (agt_payload),
    .agt_eom             (agt_eom),
    .sb_put              (sb_put),
    .sb_payload          (sb_payload),
    .sb_eom              (sb_eom),
    .sb_cup              (sb_cup),
    .credit_cnt          (credit_cnt),
    .cup_overflow        (cup_overflow),
    .tx_idle             (tx_idle)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb_put != '0) begin
      q_cyc.push_back(cyc);
      q_put.push_back(sb_put);
      q_dat.push_back(sb_payload);
      q_eom.push_back(sb_eom);
      q_cr0.push_back(credit_cnt[CW-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_cyc.delete(); q_put.delete(); q_dat.delete(); q_eom.delete(); q_cr0.delete();
  endtask

  task automatic idle_inputs();
    agt_valid = '0; agt_eom = '0; agt_payload = '0; sb_cup = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    total++; if (sb_put !== 2'b00)      begin bad++; $display("FAIL rst_put got=%b exp=00", sb_put); end
    total++; if (agt_ready !== 2'b00)   begin bad++; $display("FAIL rst_ready got=%b exp=00", agt_ready); end
    total++; if (credit_cnt !== 6'd0)   begin bad++; $display("FAIL rst_credit got=%h exp=0", credit_cnt); end
    total++; if (cup_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", cup_overflow); end
    total++; if (tx_idle !== 1'b1)      begin bad++; $display("FAIL rst_idle got=%b exp=1", tx_idle); end
    total++; if ({sb_payload, sb_eom} !== 9'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", {sb_payload, sb_eom}); end
    tick();
    rst = 1'b0;
    total++; if (agt_ready !== 2'b00) begin bad++; $display("FAIL ready_at_release got=%b exp=00", agt_ready); end
    tick();
    total++; if (agt_ready !== 2'b11) begin bad++; $display("FAIL ready_after_release got=%b exp=11", agt_ready); end
  endtask

  task automatic test_single_msg();
    int acc;
    acc = 0;
    do_reset();
    sb_cup = 2'b01;
    tick();
    sb_cup = 2'b00;
    total++; if (credit_cnt[2:0] !== 3'd1) begin bad++; $display("FAIL t1_credit_up got=%0d exp=1", credit_cnt[2:0]); end
    for (int i = 0; i < 4; i++) begin
      agt_valid   = 2'b01;
      agt_payload = {8'h00, PW'(8'hA0 + i)};
      agt_eom     = {1'b0, (i == 3)};
      tick();
      if (i == 0) acc = cyc;
    end
    idle_inputs();
    repeat (6) tick();
    total++; if (q_put.size() !== 4) begin bad++; $display("FAIL t1_count got=%0d exp=4", q_put.size()); end
    for (int i = 0; i < 4 && i < q_put.size(); i++) begin
      total++; if (q_put[i] !== 2'b01) begin bad++; $display("FAIL t1_put[%0d] got=%b exp=01", i, q_put[i]); end
      total++; if (q_dat[i] !== PW'(8'hA0 + i)) begin bad++; $display("FAIL t1_data[%0d] got=%h exp=%h", i, q_dat[i], 8'hA0 + i); end
      total++; if (q_eom[i] !== (i == 3)) begin bad++; $display("FAIL t1_eom[%0d] got=%b exp=%b", i, q_eom[i], (i == 3)); end
      total++; if (q_cyc[i] !== acc + 1 + i) begin bad++; $display("FAIL t1_cycle[%0d] got=%0d exp=%0d", i, q_cyc[i], acc + 1 + i); end
    end
    if (q_cr0.size() > 0) begin
      total++; if (q_cr0[0] !== 3'd0) begin bad++; $display("FAIL t1_credit_consumed got=%0d exp=0", q_cr0[0]); end
    end
    total++; if (tx_idle !== 1'b1) begin bad++; $display("FAIL t1_idle_end got=%b exp=1", tx_idle); end
  endtask

  task automatic test_no_credit_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      agt_valid   = 2'b01;
      agt_payload = {8'h00, PW'(8'h30 + i)};
      agt_eom     = {1'b0, (i == 7)};
      tick();
      if (i == 6) begin
        total++; if (agt_ready[0] !== 1'b1) begin bad++; $display("FAIL t2_ready_7 got=%b exp=1", agt_ready[0]); end
      end
    end
    idle_inputs();
    total++; if (agt_ready[0] !== 1'b0) begin bad++; $display("FAIL t2_ready_full got=%b exp=0", agt_ready[0]); end
    repeat (3) tick();
    total++; if (q_put.size() !== 0) begin bad++; $display("FAIL t2_no_put got=%0d exp=0", q_put.size()); end
    total++; if (tx_idle !== 1'b0) begin bad++; $display("FAIL t2_idle_busy got=%b exp=0", tx_idle); end
    sb_cup = 2'b01;
    tick();
    sb_cup = 2'b00;
    total++; if ({agt_ready[0], sb_put} !== 3'b000) begin bad++; $display("FAIL t2_cup_edge got=%b exp=000", {agt_ready[0], sb_put}); end
    tick();
    total++; if (sb_put !== 2'b01) begin bad++; $display("FAIL t2_first_put got=%b exp=01", sb_put); end
    total++; if (agt_ready[0] !== 1'b1) begin bad++; $display("FAIL t2_ready_back got=%b exp=1", agt_ready[0]); end
    repeat (10) tick();
    total++; if (q_put.size() !== 8) begin bad++; $display("FAIL t2_count got=%0d exp=8", q_put.size()); end
    for (int i = 0; i < 8 && i < q_put.size(); i++) begin
      total++; if (q_dat[i] !== PW'(8'h30 + i) || q_eom[i] !== (i == 7) || q_cyc[i] !== q_cyc[0] + i) begin
        bad++; $display("FAIL t2_flit[%0d] got=%h/%b/+%0d exp=%h/%b/+%0d", i, q_dat[i], q_eom[i], q_cyc[i] - q_cyc[0], 8'h30 + i, (i == 7), i);
      end
    end
  endtask

  task automatic test_round_robin();
    int acc;
    int m, k, ch;
    logic [PW-1:0] exp_dat;
    acc = 0;
    do_reset();
    sb_cup = 2'b11;
    tick();
    tick();
    sb_cup = 2'b00;
    total++; if (credit_cnt !== 6'b010_010) begin bad++; $display("FAIL t3_credits got=%b exp=010010", credit_cnt); end
    for (int i = 0; i < 6; i++) begin
      agt_valid   = 2'b11;
      agt_payload = {PW'(8'h20 + i), PW'(8'h10 + i)};
      agt_eom     = (i % 3 == 2) ? 2'b11 : 2'b00;
      tick();
      if (i == 0) acc = cyc;
    end
    idle_inputs();
    repeat (10) tick();
    total++; if (q_put.size() !== 12) begin bad++; $display("FAIL t3_count got=%0d exp=12", q_put.size()); end
    for (int j = 0; j < 12 && j < q_put.size(); j++) begin
      m  = j / 3;
      k  = j % 3;
      ch = m % 2;
      exp_dat = PW'((ch == 1 ? 8'h20 : 8'h10) + (m / 2) * 3 + k);
      total++; if (q_put[j] !== (ch == 1 ? 2'b10 : 2'b01) || q_dat[j] !== exp_dat || q_eom[j] !== (k == 2) || q_cyc[j] !== acc + 1 + j) begin
        bad++; $display("FAIL t3_flit[%0d] got=%b/%h/%b/%0d exp=ch%0d/%h/%b/%0d", j, q_put[j], q_dat[j], q_eom[j], q_cyc[j], ch, exp_dat, (k == 2), acc + 1 + j);
      end
    end
    total++; if (credit_cnt !== 6'd0) begin bad++; $display("FAIL t3_credits_end got=%b exp=0", credit_cnt); end
  endtask

  task automatic test_starve_lock();
    int acc;
    logic [NC-1:0] e_put [4];
    logic [PW-1:0] e_dat [4];
    logic          e_eom [4];
    int            e_off [4];
    e_put = '{2'b01, 2'b01, 2'b01, 2'b10};
    e_dat = '{8'h40, 8'h41, 8'h42, 8'h50};
    e_eom = '{1'b0, 1'b0, 1'b1, 1'b1};
    e_off = '{0, 1, 5, 6};
    acc = 0;
    do_reset();
    sb_cup = 2'b11;
    tick();
    sb_cup = 2'b00;
    agt_valid = 2'b11; agt_payload = {8'h50, 8'h40}; agt_eom = 2'b10;
    tick();
    acc = cyc;
    agt_valid = 2'b01; agt_payload = {8'h00, 8'h41}; agt_eom = 2'b00;
    tick();
    idle_inputs();
    tick();
    tick();
    total++; if (sb_put !== 2'b00) begin bad++; $display("FAIL t4_bubble got=%b exp=00", sb_put); end
    tick();
    agt_valid = 2'b01; agt_payload = {8'h00, 8'h42}; agt_eom = 2'b01;
    tick();
    idle_inputs();
    repeat (6) tick();
    total++; if (q_put.size() !== 4) begin bad++; $display("FAIL t4_count got=%0d exp=4", q_put.size()); end
    for (int i = 0; i < 4 && i < q_put.size(); i++) begin
      total++; if (q_put[i] !== e_put[i] || q_dat[i] !== e_dat[i] || q_eom[i] !== e_eom[i] || q_cyc[i] !== acc + 1 + e_off[i]) begin
        bad++; $display("FAIL t4_flit[%0d] got=%b/%h/%b/%0d exp=%b/%h/%b/%0d", i, q_put[i], q_dat[i], q_eom[i], q_cyc[i], e_put[i], e_dat[i], e_eom[i], acc + 1 + e_off[i]);
      end
    end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    sb_cup = 2'b01;
    repeat (4) tick();
    total++; if (credit_cnt[2:0] !== 3'd4 || cup_overflow !== 1'b0) begin bad++; $display("FAIL t5_at_max got=%0d/%b exp=4/0", credit_cnt[2:0], cup_overflow); end
    tick();
    sb_cup = 2'b00;
    total++; if (credit_cnt[2:0] !== 3'd4 || cup_overflow !== 1'b1) begin bad++; $display("FAIL t5_overflow got=%0d/%b exp=4/1", credit_cnt[2:0], cup_overflow); end
    repeat (3) tick();
    total++; if (cup_overflow !== 1'b1) begin bad++; $display("FAIL t5_sticky got=%b exp=1", cup_overflow); end
    sb_cup = 2'b10;
    tick();
    tick();
    sb_cup = 2'b00;
    total++; if (credit_cnt[5:3] !== 3'd2) begin bad++; $display("FAIL t5_ch1_two got=%0d exp=2", credit_cnt[5:3]); end
    agt_valid = 2'b10; agt_payload = {8'h77, 8'h00}; agt_eom = 2'b10;
    tick();
    idle_inputs();
    sb_cup = 2'b10;
    tick();
    sb_cup = 2'b00;
    total++; if ({sb_put, sb_payload, sb_eom} !== {2'b10, 8'h77, 1'b1}) begin bad++; $display("FAIL t5_put got=%b/%h/%b exp=10/77/1", sb_put, sb_payload, sb_eom); end
    total++; if (credit_cnt !== {3'd2, 3'd4}) begin bad++; $display("FAIL t5_coincident got=%b exp=010100", credit_cnt); end
    do_reset();
    total++; if (cup_overflow !== 1'b0) begin bad++; $display("FAIL t5_ovf_cleared got=%b exp=0", cup_overflow); end
  endtask

  task automatic test_reset_mid_msg();
    do_reset();
    sb_cup = 2'b01;
    tick();
    sb_cup = 2'b00;
    agt_valid = 2'b01; agt_payload = {8'h00, 8'h60}; agt_eom = 2'b00;
    tick();
    agt_payload = {8'h00, 8'h61};
    tick();
    total++; if (sb_put !== 2'b01 || sb_payload !== 8'h60) begin bad++; $display("FAIL t6_pre_put got=%b/%h exp=01/60", sb_put, sb_payload); end
    rst = 1'b1;
    #1;
    total++; if (sb_put !== 2'b00) begin bad++; $display("FAIL t6_put_cleared got=%b exp=00", sb_put); end
    total++; if (credit_cnt !== 6'd0) begin bad++; $display("FAIL t6_credit_cleared got=%b exp=0", credit_cnt); end
    idle_inputs();
    tick();
    rst = 1'b0;
    clear_mon();
    total++; if (tx_idle !== 1'b1 || agt_ready !== 2'b00) begin bad++; $display("FAIL t6_release got=%b/%b exp=1/00", tx_idle, agt_ready); end
    tick();
    total++; if (agt_ready !== 2'b11) begin bad++; $display("FAIL t6_ready got=%b exp=11", agt_ready); end
    sb_cup = 2'b01;
    tick();
    sb_cup = 2'b00;
    repeat (6) tick();
    total++; if (q_put.size() !== 0) begin bad++; $display("FAIL t6_stale got=%0d exp=0", q_put.size()); end
    total++; if (credit_cnt[2:0] !== 3'd1 || tx_idle !== 1'b1) begin bad++; $display("FAIL t6_after got=%0d/%b exp=1/1", credit_cnt[2:0], tx_idle); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_single_msg();
    test_no_credit_full();
    test_round_robin();
    test_starve_lock();
    test_credit_overflow();
    test_reset_mid_msg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
